// File: rtl/restoring_divider.sv
// Unsigned multi-cycle restoring divider: one quotient bit per clock, WIDTH cycles per division.
// Divide-by-zero finishes in one cycle with quotient all ones and remainder equal to the dividend.
module restoring_divider #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] div_reg;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] q_work;
  logic [WIDTH:0]   p_shift;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic [WIDTH-1:0] p_next;
  logic [WIDTH-1:0] q_next;
  logic             accept;

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  // The stored remainder is always below the divisor, so WIDTH bits hold it; the shifted
  // partial remainder and the trial difference need the extra bit to detect the borrow.
  always_comb begin
    p_shift = {p, q_work[WIDTH-1]};
    trial   = p_shift - {1'b0, div_reg};
    borrow  = trial[WIDTH];
    p_next  = borrow ? p_shift[WIDTH-1:0] : trial[WIDTH-1:0];
    q_next  = {q_work[WIDTH-2:0], ~borrow};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: begin
        if (start)              next_state = (divisor == '0) ? DONE : RUN;
        else if (state == DONE) next_state = IDLE;
      end
      RUN: if (count == LAST) next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  // Results only change at completion, so they hold across a following division.
  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      div_reg     <= '0;
      p           <= '0;
      q_work      <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      count   <= '0;
      div_reg <= divisor;
      p       <= '0;
      q_work  <= dividend;
      if (divisor == '0) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (state == RUN) begin
      count  <= count + CNT_W'(1);
      p      <= p_next;
      q_work <= q_next;
      if (count == LAST) begin
        quotient    <= q_next;
        remainder   <= p_next;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Directed and random checks of restoring_divider (WIDTH=20): results, latency, reset, start handling.
module tb_restoring_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic [19:0] dividend;
  logic [19:0] divisor;
  logic        busy;
  logic        done;
  logic [19:0] quotient;
  logic [19:0] remainder;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  restoring_divider #(.WIDTH(20)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present operands with start and hold them through one rising edge.
  task automatic apply_stimulus(input logic [19:0] a, input logic [19:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts falling edges after acceptance until done; optionally fires a stray start mid-run.
  task automatic wait_done(input int poke_at, input logic [19:0] pa, input logic [19:0] pb,
                           output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) break;
      if (lat == poke_at) begin
        start    = 1'b1;
        dividend = pa;
        divisor  = pb;
      end else if (lat == poke_at + 1) begin
        start = 1'b0;
      end
    end
  endtask

  task automatic run_div(input string tag, input logic [19:0] a, input logic [19:0] b,
                         input logic [19:0] exp_q, input logic [19:0] exp_r);
    int lat, bc;
    apply_stimulus(a, b);
    wait_done(-10, '0, '0, lat, bc);
    check_output({tag, "_lat"}, 64'(lat), 64'(21));
    check_output({tag, "_q"}, 64'(quotient), 64'(exp_q));
    check_output({tag, "_r"}, 64'(remainder), 64'(exp_r));
    check_output({tag, "_dbz"}, 64'(div_by_zero), 64'(0));
  endtask

  initial begin
    int lat, bc, pulses;
    logic [19:0] a, b;

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_output("rst_busy", 64'(busy), 64'(0));
    check_output("rst_done", 64'(done), 64'(0));
    check_output("rst_q", 64'(quotient), 64'(0));
    check_output("rst_r", 64'(remainder), 64'(0));
    check_output("rst_dbz", 64'(div_by_zero), 64'(0));

    apply_stimulus(20'd100, 20'd7);
    wait_done(-10, '0, '0, lat, bc);
    check_output("n_lat", 64'(lat), 64'(21));
    check_output("n_busy", 64'(bc), 64'(20));
    check_output("n_q", 64'(quotient), 64'(14));
    check_output("n_r", 64'(remainder), 64'(2));
    check_output("n_dbz", 64'(div_by_zero), 64'(0));
    @(negedge clk);
    check_output("n_pulse", 64'(done), 64'(0));
    check_output("n_hold_q", 64'(quotient), 64'(14));

    run_div("max_1", 20'hFFFFF, 20'd1, 20'hFFFFF, 20'd0);
    run_div("small", 20'd3, 20'd10, 20'd0, 20'd3);
    run_div("max_max", 20'hFFFFF, 20'hFFFFF, 20'd1, 20'd0);

    apply_stimulus(20'd5, 20'd0);
    wait_done(-10, '0, '0, lat, bc);
    check_output("z_lat", 64'(lat), 64'(1));
    check_output("z_busy", 64'(bc), 64'(0));
    check_output("z_dbz", 64'(div_by_zero), 64'(1));
    check_output("z_q", 64'(quotient), 64'(20'hFFFFF));
    check_output("z_r", 64'(remainder), 64'(5));
    @(negedge clk);
    check_output("z_pulse", 64'(done), 64'(0));
    check_output("z_hold_dbz", 64'(div_by_zero), 64'(1));

    // A start during RUN with new operands must be dropped.
    apply_stimulus(20'd100, 20'd7);
    wait_done(5, 20'd50, 20'd5, lat, bc);
    check_output("sb_lat", 64'(lat), 64'(21));
    check_output("sb_q", 64'(quotient), 64'(14));
    check_output("sb_r", 64'(remainder), 64'(2));
    check_output("sb_dbz", 64'(div_by_zero), 64'(0));
    @(negedge clk);
    check_output("sb_idle", 64'(busy), 64'(0));

    apply_stimulus(20'd100, 20'd7);
    wait_done(-10, '0, '0, lat, bc);
    check_output("bb1_q", 64'(quotient), 64'(14));
    apply_stimulus(20'd1000, 20'd3);
    wait_done(-10, '0, '0, lat, bc);
    check_output("bb2_lat", 64'(lat), 64'(21));
    check_output("bb2_q", 64'(quotient), 64'(333));
    check_output("bb2_r", 64'(remainder), 64'(1));

    apply_stimulus(20'd100, 20'd7);
    repeat (9) @(negedge clk);
    check_output("mr_hold_q", 64'(quotient), 64'(333));
    check_output("mr_busy", 64'(busy), 64'(1));
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_output("mr_busy0", 64'(busy), 64'(0));
    check_output("mr_q0", 64'(quotient), 64'(0));
    check_output("mr_r0", 64'(remainder), 64'(0));
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      if (done === 1'b1) pulses++;
      @(negedge clk);
    end
    check_output("mr_nodone", 64'(pulses), 64'(0));
    run_div("post_rst", 20'd9, 20'd4, 20'd2, 20'd1);

    for (int n = 0; n < 1000; n++) begin
      a = 20'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 20'($urandom_range(1, 15)) : 20'($urandom);
      if (b == '0) b = 20'd1;
      apply_stimulus(a, b);
      wait_done(-10, '0, '0, lat, bc);
      check_output("rnd_inv", 64'(quotient) * 64'(b) + 64'(remainder), 64'(a));
      check_output("rnd_rlt", 64'(remainder < b), 64'(1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/restoring_divider.md
RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 Parameter WIDTH, default 20: operand and result width in bits; all values below assume WIDTH=20.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a division; sampled on the rising edge.
REQ-005 dividend  input  WIDTH  unsigned dividend; captured when start is accepted.
REQ-006 divisor  input  WIDTH  unsigned divisor; captured when start is accepted.
REQ-007 busy  output  1  high while an iteration is in progress.
REQ-008 done  output  1  single-cycle pulse that marks the results as valid.
REQ-009 quotient  output  WIDTH  unsigned quotient.
REQ-010 remainder  output  WIDTH  unsigned remainder.
REQ-011 div_by_zero  output  1  high with done when the captured divisor is 0.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-013 start SHALL be accepted only in IDLE or DONE; on acceptance the block SHALL capture dividend and divisor and clear the iteration counter.
REQ-014 On acceptance with divisor!=0, the FSM SHALL enter RUN.
REQ-015 On acceptance with divisor==0, the FSM SHALL enter DONE directly.
REQ-016 start asserted in RUN SHALL be ignored, with no capture and no effect on the running division.
REQ-017 Each RUN cycle SHALL perform one restoring step:
- partial remainder P (WIDTH+1 bits) shifted left, taking in the MSB of the working quotient;
- working quotient shifted left;
- trial difference T = P - divisor computed at WIDTH+1 bits;
- if T is non-negative (no borrow), P SHALL become T and quotient bit 0 SHALL be set to 1; otherwise P SHALL be kept and bit 0 SHALL be 0.
REQ-018 RUN SHALL last exactly WIDTH cycles (counter 0..WIDTH-1), after which the FSM SHALL enter DONE.
REQ-019 Latency: start accepted at edge k -> busy high for edges k+1..k+WIDTH, done high for the single cycle after edge k+WIDTH (21 cycles for WIDTH=20).
REQ-020 Divide-by-zero latency: done and div_by_zero SHALL both be high for the single cycle after edge k, with busy staying 0.
REQ-021 DONE SHALL last one cycle; the FSM SHALL then go to IDLE unless start is asserted in DONE, in which case the new division SHALL be accepted (back-to-back operation).
REQ-022 Divide-by-zero results SHALL be quotient = all ones (20'hFFFFF) and remainder = the captured dividend.
REQ-023 quotient, remainder and div_by_zero SHALL be registered and SHALL hold their values from done until the next done, including while a later division is running.
REQ-024 Result invariant: for divisor!=0, quotient*divisor + remainder SHALL equal dividend, with remainder < divisor.
REQ-025 The block SHALL be purely unsigned; no signed interpretation or overflow flag SHALL exist.
REQ-026 Changes on dividend or divisor after capture SHALL have no effect on the division in progress.

Reset
REQ-027 While rst is high at a clock edge, the FSM SHALL go to IDLE and busy, done, div_by_zero, quotient, remainder, the counter and the working registers SHALL all go to 0.
REQ-028 Reset SHALL take priority over start.
REQ-029 Reset asserted during RUN SHALL abort the division with no done pulse.
REQ-030 The first start accepted after rst is released SHALL behave exactly as it would from power-up.

Verification
REQ-031 Normal division: dividend=100, divisor=7 -> done on the 21st cycle after acceptance, quotient=14, remainder=2, div_by_zero=0.
REQ-032 Boundaries:
- 20'hFFFFF/1 -> quotient=20'hFFFFF, remainder=0;
- 3/10 -> quotient=0, remainder=3;
- 20'hFFFFF/20'hFFFFF -> quotient=1, remainder=0.
REQ-033 Divide by zero: 5/0 -> done=1 and div_by_zero=1 one cycle after acceptance, quotient=20'hFFFFF, remainder=5, busy never high.
REQ-034 Start while busy: accept 100/7, then assert start with 50/5 at RUN cycle 5 -> results 14/2 with unchanged latency; the 50/5 request is dropped.
REQ-035 Back-to-back: start held through the DONE cycle of 100/7 with new operands 1000/3 -> second done exactly 21 cycles later with quotient=333, remainder=1.
REQ-036 Reset mid-run: rst at RUN cycle 10 -> next cycle busy=0, quotient=0, remainder=0, and no done pulse appears; a following 9/4 -> quotient=2, remainder=1.
REQ-037 The bench SHALL also run at least 1000 random operand pairs checked against the REQ-024 invariant.
